cas_player: RTL

// Cassette playback scheduler for the HT1080Z core. Sequences the cassette image held in the

---
 rtl/cas_player.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cas_player.sv
// Cassette playback scheduler: streams the cassette image byte by byte through a
// req/ack read port and turns each byte into TRS-80 Level II 500-baud pulses,
// MSB first. Every bit cell starts with a clock pulse. A second pulse in the
// middle of the cell marks a 1 bit. Timing counts CPU clock enables, so the
// stream follows the CPU speed. It also stalls while the cassette motor relay
// is open.
module cas_player #(
    parameter int CELL_TICKS  = 3548,
    parameter int PULSE_TICKS = 228,
    parameter int DATA_OFS    = 1774
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce,
    input  logic        motor,
    input  logic        start,
    input  logic        stop,
    input  logic        rewind,
    input  logic [15:0] len,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic        rd_ack,
    input  logic [7:0]  rd_data,
    output logic        tape_out,
    output logic        busy,
    output logic        done
);

    localparam int CW = $clog2(CELL_TICKS);
    localparam logic [CW-1:0] CELL_LAST = CW'(CELL_TICKS - 1);
    localparam logic [CW-1:0] PULSE_END = CW'(PULSE_TICKS);
    localparam logic [CW-1:0] DATA_BEG  = CW'(DATA_OFS);
    localparam logic [CW-1:0] DATA_END  = CW'(DATA_OFS + PULSE_TICKS);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_CELL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     rd_addr_q, rd_addr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            rd_req_q, rd_req_d;
    logic            tape_q, tape_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [16:0]     next_addr_s;
    logic            halt_s;

    // Pulse level for a given tick in the cell: a clock pulse at the start,
    // plus a data pulse in the middle of the cell for a 1 bit.
    function automatic logic pulse_at(input logic [CW-1:0] cnt, input logic bit_val);
        pulse_at = (cnt < PULSE_END) ||
                   (bit_val && (cnt >= DATA_BEG) && (cnt < DATA_END));
    endfunction

    // The next address is widened so that the compare against len cannot wrap.
    assign next_addr_s = {1'b0, rd_addr_q} + 17'd1;
    assign halt_s      = stop | rewind;

    // Next-state logic: sequencing, byte fetch, cell tick counting, control strobes.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (rd_addr_q < len) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (rd_ack) begin
                    shift_d = rd_data;
                    cnt_d   = CNT_ZERO;
                    bit_d   = 3'd7;
                    state_d = S_CELL;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_CELL: begin
                if (ce && motor) begin
                    if (cnt_q == CELL_LAST) begin
                        cnt_d = CNT_ZERO;
                        if (bit_q != 3'd0) begin
                            bit_d = bit_q - 3'd1;
                        end else begin
                            rd_addr_d = next_addr_s[15:0];
                            if (next_addr_s < {1'b0, len}) begin
                                state_d = S_FETCH;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Rewind wins over stop, and both win over anything the state decided.
        // A same-cycle rd_ack is dropped: the byte is fetched again on restart.
        if (rewind) begin
            state_d   = S_IDLE;
            rd_addr_d = 16'd0;
            cnt_d     = CNT_ZERO;
            bit_d     = 3'd7;
        end else if (stop) begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
            bit_d   = 3'd7;
        end else begin
            state_d = state_d;
        end
    end

    // Output decode. rd_req follows the next state. tape/busy/done follow the
    // current state one cycle later. All outputs are forced idle when stop or
    // rewind is asserted.
    always_comb begin
        rd_req_d = (state_d == S_FETCH);
        tape_d   = (state_q == S_CELL) && motor && !halt_s && pulse_at(cnt_q, shift_q[bit_q]);
        busy_d   = ((state_q == S_FETCH) || (state_q == S_CELL)) && !halt_s;
        done_d   = (state_q == S_DONE) && !halt_s;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rd_addr_q <= 16'd0;
            cnt_q     <= CNT_ZERO;
            bit_q     <= 3'd7;
            shift_q   <= 8'd0;
            rd_req_q  <= 1'b0;
            tape_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rd_req_q  <= rd_req_d;
            tape_q    <= tape_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rd_req   = rd_req_q;
    assign rd_addr  = rd_addr_q;
    assign tape_out = tape_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
